// File: rtl/fifo_queue.sv
// fifo_queue: first-word fall-through circular-buffer FIFO with registered head output.
// Ports:
//   clk     - clock, all state changes on its rising edge
//   rst_n   - asynchronous active-low reset (pointers, count, dout cleared; memory kept)
//   din     - write data, captured on an accepted enqueue
//   enq     - enqueue request, accepted only while full_n=1
//   full_n  - high while fewer than FIFO_DEPTH entries are stored
//   dout    - registered head-of-queue data; holds last head while empty
//   deq     - dequeue request, accepted only while empty_n=1
//   empty_n - high while at least one entry is stored
//   clr     - synchronous clear, overrides enq and deq
// Optional macro FIFO_PROTOCOL_CHECK_EN adds simulation-only overflow/underflow messages.
module fifo_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int COUNTER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  enq,
    output logic                  full_n,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  deq,
    output logic                  empty_n,
    input  logic                  clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CNT_W-1:0]      count;
    logic                  enq_ok, deq_ok;
    logic [DATA_WIDTH-1:0] dout_nxt;
    logic [31:0]           unused_cw;

    // COUNTER_WIDTH only exists for port-map compatibility; sizing comes from FIFO_DEPTH.
    assign unused_cw = COUNTER_WIDTH;

    assign full_n  = count != FULL_CNT;
    assign empty_n = count != '0;
    assign enq_ok  = enq && full_n;
    assign deq_ok  = deq && empty_n;
    assign rd_nxt  = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    assign wr_nxt  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);

    // Next head: the following stored entry after a pop, or incoming data when it
    // becomes the only entry (empty, or last entry popped in the same cycle).
    // Otherwise hold, so an empty FIFO keeps showing its last head.
    always_comb begin
        dout_nxt = (deq_ok && count > ONE) ? mem[rd_nxt] :
                   (enq_ok && (count == '0 || (count == ONE && deq_ok))) ? din : dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (enq_ok) wr_ptr <= wr_nxt;
            if (deq_ok) rd_ptr <= rd_nxt;
            count <= count + CNT_W'(enq_ok) - CNT_W'(deq_ok);
            dout  <= dout_nxt;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst_n && enq_ok && !clr) mem[wr_ptr] <= din;
    end

`ifdef FIFO_PROTOCOL_CHECK_EN
    always @(posedge clk) begin
        if (rst_n && !clr && enq && !full_n) $error("fifo_queue: enq while full");
        if (rst_n && !clr && deq && !empty_n) $error("fifo_queue: deq while empty");
    end
`else
    // protocol checking disabled
`endif
endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue: randomized and directed checks of fifo_queue against a queue model.
module tb_fifo_queue;
    localparam int DW = 4;
    localparam int DEPTH = 3;

    logic          clk, rst_n, enq, deq, clr;
    logic [DW-1:0] din, dout;
    logic          full_n, empty_n;

    int       total = 0;
    int       bad = 0;
    int       q[$];
    int       dout_m = 0;

    fifo_queue #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COUNTER_WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .enq(enq), .full_n(full_n),
        .dout(dout), .deq(deq), .empty_n(empty_n), .clr(clr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"}, int'(dout), dout_m);
        check({tag, ".empty_n"}, int'(empty_n), int'(q.size() != 0));
        check({tag, ".full_n"}, int'(full_n), int'(q.size() != DEPTH));
    endtask

    // One clock: drive at the falling edge, apply the model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input string tag, input bit e, input bit d, input bit c, input int data);
        bit acc_e, acc_d;
        enq = e; deq = d; clr = c; din = DW'(data);
        @(posedge clk);
        if (c) begin
            q.delete();
            dout_m = 0;
        end else begin
            acc_e = e && q.size() < DEPTH;
            acc_d = d && q.size() > 0;
            if (acc_d) void'(q.pop_front());
            if (acc_e) q.push_back(data);
            if (q.size() > 0) dout_m = q[0];
        end
        @(negedge clk);
        enq = 0; deq = 0; clr = 0;
        check_all(tag);
    endtask

    initial begin
        rst_n = 0; enq = 0; deq = 0; clr = 0; din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        check_all("reset");

        for (int i = 0; i < 3; i++) step("fill", 1, 0, 0, i);
        step("fill_drop", 1, 0, 0, 7);

        for (int i = 0; i < 3; i++) step("drain", 0, 1, 0, 0);
        step("deq_empty", 0, 1, 0, 0);

        step("clr_pre", 1, 0, 0, 3);
        step("clr", 0, 0, 1, 0);
        step("clr_enq", 1, 0, 1, 9);

        step("lat_enq4", 1, 0, 0, 4);
        step("lat_enq5_deq", 1, 1, 0, 5);
        step("lat_deq", 0, 1, 0, 0);

        for (int i = 0; i < 10; i++) step("wrap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, int'($urandom_range(0, 15)));

        step("full_enq_deq_a", 1, 0, 0, 10);
        step("full_enq_deq_b", 1, 0, 0, 11);
        step("full_enq_deq_c", 1, 0, 0, 12);
        step("full_enq_deq", 1, 1, 0, 13);

        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)));

        step("pre_areset", 1, 0, 0, 6);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        q.delete();
        dout_m = 0;
        check_all("areset");
        @(negedge clk);
        rst_n = 1;
        step("post_areset", 1, 0, 0, 8);
        step("post_areset_deq", 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
